// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter and its reference matcher.
package seq_tx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP
   } state_t;

   localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;
   localparam int         MATCH_CNT_W     = 16;

endpackage

// File: rtl/seq_match_model.sv
// Overlapping reference matcher: 3-bit history of the line, pattern compare and a saturating
// match counter. Usable standalone as a scoreboard for a Mealy pattern detector.
module seq_match_model
   import seq_tx_pkg::*;
#(
   parameter logic [3:0] PATTERN = DEFAULT_PATTERN
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   bit_in,
   output logic                   match,
   output logic [MATCH_CNT_W-1:0] count
);

   localparam logic [MATCH_CNT_W-1:0] CNT_MAX = '1;

   logic [2:0] history;

   // Mealy-aligned: the current line bit completes the pattern in the same cycle.
   assign match = ({history, bit_in} == PATTERN);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         history <= '0;
         count   <= '0;
      end else begin
         history <= {history[1:0], bit_in};
         if (match && count != CNT_MAX)
            count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/seq_pattern_tx.sv
// Valid/ready parallel-to-serial transmitter with built-in reference matcher for "1011" detectors.
// Optional macro PARITY_EN appends an even-parity bit to every frame.
module seq_pattern_tx
   import seq_tx_pkg::*;
#(
   parameter int         WIDTH      = 8,
   parameter int         GAP_CYCLES = 2,
   parameter logic [3:0] PATTERN    = DEFAULT_PATTERN
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic                   serial_out,
   output logic                   bit_valid,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   match_exp,
   output logic [MATCH_CNT_W-1:0] match_cnt
);

`ifdef PARITY_EN
   localparam int FRAME_BITS = WIDTH + 1;
`else
   localparam int FRAME_BITS = WIDTH;
`endif
   localparam int BIT_CNT_W = $clog2(FRAME_BITS);
   localparam int GAP_CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   state_t                 state;
   state_t                 next_state;
   logic                   accept;
   logic [FRAME_BITS-1:0]  frame_word;
   logic [FRAME_BITS-1:0]  shreg;
   logic [BIT_CNT_W-1:0]   bit_cnt;
   logic [GAP_CNT_W-1:0]   gap_cnt;

`ifdef PARITY_EN
   assign frame_word = {in_data, ^in_data};
`else
   assign frame_word = in_data;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = SHIFT;
         SHIFT:   if (bit_cnt == '0) next_state = GAP;
         GAP:     if (gap_cnt == '0) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == IDLE);
      busy     = (state != IDLE);
      accept   = in_valid && (state == IDLE);
   end

   // Line outputs are registered so the matcher compare depends on flops only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg      <= '0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         serial_out <= 1'b0;
         bit_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  serial_out <= frame_word[FRAME_BITS-1];
                  shreg      <= frame_word << 1;
                  bit_valid  <= 1'b1;
                  bit_cnt    <= BIT_CNT_W'(FRAME_BITS - 1);
               end
            end
            SHIFT: begin
               if (bit_cnt == '0) begin
                  serial_out <= 1'b0;
                  bit_valid  <= 1'b0;
                  frame_done <= 1'b1;
                  gap_cnt    <= GAP_CNT_W'(GAP_CYCLES - 1);
               end else begin
                  serial_out <= shreg[FRAME_BITS-1];
                  shreg      <= shreg << 1;
                  bit_cnt    <= bit_cnt - 1'b1;
               end
            end
            GAP: begin
               if (gap_cnt != '0)
                  gap_cnt <= gap_cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

   seq_match_model #(
      .PATTERN (PATTERN)
   ) u_match (
      .clk    (clk),
      .reset  (reset),
      .bit_in (serial_out),
      .match  (match_exp),
      .count  (match_cnt)
   );

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: per-bit scoreboard of line value, match strobe and count.
// Honours PARITY_EN when compiled with the same define as the RTL.
module tb_seq_pattern_tx;

   localparam int         WIDTH = 8;
   localparam int         GAP   = 2;
   localparam logic [3:0] PAT   = 4'b1011;
`ifdef PARITY_EN
   localparam int FB = WIDTH + 1;
`else
   localparam int FB = WIDTH;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             serial_out;
   logic             bit_valid;
   logic             busy;
   logic             frame_done;
   logic             match_exp;
   logic [15:0]      match_cnt;

   typedef struct {
      logic b;
      logic m;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] exp_cnt;
   int          vectors     = 0;
   int          miscompares = 0;
   int          cycle       = 0;

   seq_pattern_tx #(
      .WIDTH      (WIDTH),
      .GAP_CYCLES (GAP),
      .PATTERN    (PAT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .serial_out (serial_out),
      .bit_valid  (bit_valid),
      .busy       (busy),
      .frame_done (frame_done),
      .match_exp  (match_exp),
      .match_cnt  (match_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns at the negedge where the first frame bit is on the line.
   task automatic wait_accept(output int t);
      bit ok = 1'b0;
      t = -1;
      for (int i = 0; i < 64; i++) begin
         if (in_ready === 1'b1) begin
            ok = 1'b1;
            t  = cycle;
            break;
         end
         @(negedge clk);
      end
      if (!ok)
         check("accept_timeout", 32'd0, 32'd1);
      else
         @(negedge clk);
   endtask

   // Bench model: history is all zeros at frame start because gap plus idle is at least 3 zero cycles.
   task automatic expect_frame(input logic [WIDTH-1:0] w, input int pulse_at);
      logic [FB-1:0] fw;
      logic [2:0]    h = 3'b000;
      exp_t          e;
`ifdef PARITY_EN
      fw = {w, ^w};
`else
      fw = w;
`endif
      for (int i = FB - 1; i >= 0; i--) begin
         e.b = fw[i];
         e.m = ({h, fw[i]} == PAT);
         h   = {h[1:0], fw[i]};
         sb.push_back(e);
      end
      for (int k = 1; k <= FB; k++) begin
         e = sb.pop_front();
         check($sformatf("bit%0d_out", k), 32'(serial_out), 32'(e.b));
         check($sformatf("bit%0d_valid", k), 32'(bit_valid), 32'd1);
         check($sformatf("bit%0d_match", k), 32'(match_exp), 32'(e.m));
         check($sformatf("bit%0d_cnt", k), 32'(match_cnt), 32'(exp_cnt));
         if (e.m && exp_cnt != 16'hFFFF)
            exp_cnt = exp_cnt + 16'd1;
         if (k == pulse_at) begin
            in_data  = ~w;
            in_valid = 1'b1;
            check("ready_in_shift", 32'(in_ready), 32'd0);
         end else if (k == pulse_at + 1) begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      check("done_pulse", 32'(frame_done), 32'd1);
      check("gap_valid", 32'(bit_valid), 32'd0);
      check("gap_out", 32'(serial_out), 32'd0);
      check("gap_busy", 32'(busy), 32'd1);
      check("frame_cnt", 32'(match_cnt), 32'(exp_cnt));
      @(negedge clk);
      check("done_one_cycle", 32'(frame_done), 32'd0);
      check("gap2_busy", 32'(busy), 32'd1);
   endtask

   initial begin
      int t0, t1, n;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      exp_cnt  = 16'd0;
      repeat (2) @(negedge clk);
      check("rst_out", 32'(serial_out), 32'd0);
      check("rst_valid", 32'(bit_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(frame_done), 32'd0);
      check("rst_cnt", 32'(match_cnt), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);
      reset = 1'b0;
      @(negedge clk);

      // Single frame 8'h5B: matches on bits 5 and 8.
      in_data  = 8'h5B;
      in_valid = 1'b1;
      wait_accept(t0);
      in_valid = 1'b0;
      expect_frame(8'h5B, -1);
      check("t1_cnt", 32'(match_cnt), 32'd2);
      repeat (2) @(negedge clk);

      // Back-to-back with in_valid held: accept spacing is the minimum frame period.
      in_data  = 8'hB0;
      in_valid = 1'b1;
      wait_accept(t0);
      in_data = 8'h0B;
      expect_frame(8'hB0, -1);
      wait_accept(t1);
      in_valid = 1'b0;
      expect_frame(8'h0B, -1);
      check("b2b_period", 32'(t1 - t0), 32'(FB + GAP + 1));
      check("b2b_cnt", 32'(match_cnt), 32'd4);
      repeat (2) @(negedge clk);

      // in_valid pulsed during SHIFT is ignored.
      in_data  = 8'h5B;
      in_valid = 1'b1;
      wait_accept(t0);
      in_valid = 1'b0;
      expect_frame(8'h5B, 3);
      n = 0;
      repeat (20) begin
         @(negedge clk);
         if (bit_valid) n++;
      end
      check("no_extra_frame", 32'(n), 32'd0);

      // Reset at bit 3 aborts the frame silently.
      in_data  = 8'h5B;
      in_valid = 1'b1;
      wait_accept(t0);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      exp_cnt = 16'd0;
      check("abort_out", 32'(serial_out), 32'd0);
      check("abort_valid", 32'(bit_valid), 32'd0);
      check("abort_cnt", 32'(match_cnt), 32'd0);
      check("abort_done", 32'(frame_done), 32'd0);
      check("abort_ready", 32'(in_ready), 32'd1);
      reset = 1'b0;
      n = 0;
      repeat (12) begin
         @(negedge clk);
         if (frame_done || bit_valid) n++;
      end
      check("abort_quiet", 32'(n), 32'd0);

      // Counter saturation from a preloaded value.
      force dut.u_match.count = 16'hFFFE;
      @(negedge clk);
      release dut.u_match.count;
      @(negedge clk);
      exp_cnt = 16'hFFFE;
      check("preload_cnt", 32'(match_cnt), 32'h0000FFFE);
      in_data  = 8'h5B;
      in_valid = 1'b1;
      wait_accept(t0);
      in_valid = 1'b0;
      expect_frame(8'h5B, -1);
      check("sat_cnt", 32'(match_cnt), 32'h0000FFFF);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
